// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, sample/frame types and FSM state encoding for the FFT framer
package fft_pkg;

    localparam int SAMPLE_W = 16;
    localparam int N_POINTS = 16;
    localparam int STAGES   = $clog2(N_POINTS);

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef sample_t [N_POINTS-1:0] frame_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/fft_collect_buffer.sv
// rtl/fft_collect_buffer.sv - serial sample collector with wrapping write pointer and frame_full strobe
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   sample_in     incoming sample, written at wr_ptr when sample_valid
//   sample_valid  write strobe; wr_ptr advances and wraps N_POINTS-1 -> 0
//   frame_next    collected frame with sample_in already placed in the last slot,
//                 so the top level can capture a completed frame on the completing edge
//   frame_full    combinational strobe: this edge writes the last slot of a frame
module fft_collect_buffer #(
    parameter int SAMPLE_W = 16,
    parameter int N_POINTS = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SAMPLE_W-1:0]          sample_in,
    input  logic                         sample_valid,
    output logic [N_POINTS*SAMPLE_W-1:0] frame_next,
    output logic                         frame_full
);

    localparam int PTR_W = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

    logic [SAMPLE_W-1:0] collect [N_POINTS];
    logic [PTR_W-1:0]    wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            for (int k = 0; k < N_POINTS; k++) begin
                collect[k] <= '0;
            end
        end else if (sample_valid) begin
            collect[wr_ptr] <= sample_in;
            wr_ptr          <= (wr_ptr == PTR_W'(N_POINTS - 1)) ? '0 : wr_ptr + 1'b1;
        end
    end

    assign frame_full = sample_valid && (wr_ptr == PTR_W'(N_POINTS - 1));

    // The last slot is bypassed from sample_in: it is only ever meaningful on the
    // completing edge, before the register file itself has been written.
    always_comb begin
        frame_next = '0;
        for (int k = 0; k < N_POINTS; k++) begin
            frame_next[k*SAMPLE_W +: SAMPLE_W] = (k == N_POINTS - 1) ? sample_in : collect[k];
        end
    end

endmodule

// File: rtl/fft_sample_framer.sv
// rtl/fft_sample_framer.sv - frames a serial sample stream and sequences the FFT load/run interface
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   sample_in      audio sample, taken whenever sample_valid is high (no backpressure)
//   sample_valid   sample strobe
//   overrun_clr    synchronous clear of the sticky overrun flag
//   frame_out      held frame, t_k = frame_out[k*SAMPLE_W +: SAMPLE_W]
//   new_t          0 = FFT loads frame_out, 1 = FFT runs one butterfly stage
//   busy           high in LOAD and RUN
//   result_valid   one-cycle pulse in the first IDLE cycle after RUN
//   overrun        sticky: a completed frame arrived while busy and was dropped
module fft_sample_framer #(
    parameter int SAMPLE_W = fft_pkg::SAMPLE_W,
    parameter int N_POINTS = fft_pkg::N_POINTS,
    parameter int STAGES   = fft_pkg::STAGES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SAMPLE_W-1:0]          sample_in,
    input  logic                         sample_valid,
    input  logic                         overrun_clr,
    output logic [N_POINTS*SAMPLE_W-1:0] frame_out,
    output logic                         new_t,
    output logic                         busy,
    output logic                         result_valid,
    output logic                         overrun
);

    import fft_pkg::*;

    localparam int CNT_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic [N_POINTS*SAMPLE_W-1:0] frame_next;
    logic                         frame_full;
    state_t                       state;
    state_t                       state_nxt;
    logic [CNT_W-1:0]             stage_cnt;
    logic                         last_stage;

    fft_collect_buffer #(
        .SAMPLE_W (SAMPLE_W),
        .N_POINTS (N_POINTS)
    ) u_collect (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .frame_next   (frame_next),
        .frame_full   (frame_full)
    );

    assign last_stage = (state == RUN) && (stage_cnt == CNT_W'(STAGES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        new_t     = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (frame_full) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                busy  = 1'b1;
                new_t = 1'b1;
                if (last_stage) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_cnt    <= '0;
            frame_out    <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (state == RUN && !last_stage) begin
                stage_cnt <= stage_cnt + 1'b1;
            end else begin
                stage_cnt <= '0;
            end

            // frame_out only moves on IDLE->LOAD, keeping it stable for the whole run.
            if (state == IDLE && frame_full) begin
                frame_out <= frame_next;
            end

            result_valid <= last_stage;

            // A dropped frame wins over a simultaneous clear so no overrun is lost.
            if (frame_full && state != IDLE) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_sample_framer.sv
// tb/tb_fft_sample_framer.sv - scoreboard bench for fft_sample_framer
module tb_fft_sample_framer;

    localparam int W  = 16;
    localparam int N  = 16;
    localparam int S  = 4;
    localparam int SO = 20;
    localparam int FW = W * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          overrun_clr = 1'b0;
    logic [FW-1:0] frame_out;
    logic          new_t, busy, result_valid, overrun;

    logic [W-1:0]  o_sample_in = '0;
    logic          o_sample_valid = 1'b0;
    logic          o_overrun_clr = 1'b0;
    logic [FW-1:0] o_frame_out;
    logic          o_new_t, o_busy, o_result_valid, o_overrun;

    always #5 clk = ~clk;

    fft_sample_framer u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .overrun_clr  (overrun_clr),
        .frame_out    (frame_out),
        .new_t        (new_t),
        .busy         (busy),
        .result_valid (result_valid),
        .overrun      (overrun)
    );

    // Long run phase so a second frame can complete while the first is still busy.
    fft_sample_framer #(.SAMPLE_W(W), .N_POINTS(N), .STAGES(SO)) u_ovr (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (o_sample_in),
        .sample_valid (o_sample_valid),
        .overrun_clr  (o_overrun_clr),
        .frame_out    (o_frame_out),
        .new_t        (o_new_t),
        .busy         (o_busy),
        .result_valid (o_result_valid),
        .overrun      (o_overrun)
    );

    // The cycle following posedge k carries cyc == k+1.
    int cyc = 1;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [FW-1:0] frame;
        int            load_cyc;
    } exp_t;

    exp_t load_q[$];
    int   rv_q[$];
    int   run_lo = -100;
    int   run_hi = -100;
    int   rv_seen = 0;
    exp_t mon_e;
    int   mon_rv;

    always @(negedge clk) begin
        if (!rst_n) begin
            load_q.delete();
            rv_q.delete();
            run_lo = -100;
            run_hi = -100;
        end else begin
            if (busy && !new_t) begin
                if (load_q.size() == 0) begin
                    chk("unexpected_load", FW'(1), FW'(0));
                end else begin
                    mon_e = load_q.pop_front();
                    chk("load_cycle", FW'(cyc), FW'(mon_e.load_cyc));
                    chk("load_frame", frame_out, mon_e.frame);
                    run_lo = cyc + 1;
                    run_hi = cyc + S;
                end
            end
            chk("new_t", FW'(new_t), FW'(cyc >= run_lo && cyc <= run_hi));
            if (result_valid) begin
                rv_seen++;
                if (rv_q.size() == 0) begin
                    chk("unexpected_result_valid", FW'(1), FW'(0));
                end else begin
                    mon_rv = rv_q.pop_front();
                    chk("result_valid_cycle", FW'(cyc), FW'(mon_rv));
                end
            end
        end
    end

    int o_rv_cnt = 0;
    int o_rv_cyc = 0;
    always @(negedge clk) begin
        if (rst_n && o_result_valid) begin
            o_rv_cnt++;
            o_rv_cyc = cyc;
        end
    end

    logic [W-1:0] frm [N];

    function automatic logic [FW-1:0] pack_frm();
        logic [FW-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = frm[k];
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_m(input logic [W-1:0] v, input int gap);
        sample_in    = v;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        idle(gap);
    endtask

    task automatic send_o(input logic [W-1:0] v);
        o_sample_in    = v;
        o_sample_valid = 1'b1;
        @(posedge clk);
        #1;
        o_sample_valid = 1'b0;
    endtask

    // Sends frm[] into the main DUT and pushes the expected LOAD and result_valid events.
    task automatic send_frame_m(input int gap);
        int   c;
        exp_t e;
        for (int i = 0; i < N; i++) send_m(frm[i], (i == N - 1) ? 0 : gap);
        c          = cyc - 1;
        e.frame    = pack_frm();
        e.load_cyc = c + 1;
        load_q.push_back(e);
        rv_q.push_back(c + 2 + S);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_frame_out"}, frame_out, '0);
        chk({nm, "_new_t"}, FW'(new_t), FW'(0));
        chk({nm, "_busy"}, FW'(busy), FW'(0));
        chk({nm, "_result_valid"}, FW'(result_valid), FW'(0));
        chk({nm, "_overrun"}, FW'(overrun), FW'(0));
    endtask

    logic [FW-1:0] frame_a;
    logic [FW-1:0] frame_d;
    int            ca, d, rv_before, orv_before;

    initial begin
        #1;
        chk_zero("reset_async");
        idle(3);
        rst_n = 1'b1;
        chk_zero("reset_release");

        // 1: samples 1..16 back to back
        for (int i = 0; i < N; i++) frm[i] = W'(i + 1);
        send_frame_m(0);
        idle(10);

        // 2: full-scale alternating samples must pass bit-exact
        for (int i = 0; i < N; i++) frm[i] = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
        send_frame_m(0);
        idle(10);

        // 5: one sample every third cycle, same content and sequence as 1
        for (int i = 0; i < N; i++) frm[i] = W'(i + 1);
        send_frame_m(2);
        idle(10);

        // 3: second frame completes while the long-run instance is busy
        for (int i = 0; i < N; i++) frm[i] = W'(i + 1);
        frame_a    = pack_frm();
        orv_before = o_rv_cnt;
        for (int i = 0; i < N; i++) send_o(W'(i + 1));
        ca = cyc - 1;
        for (int i = 0; i < N; i++) send_o(W'(101 + i));
        chk("ovr_overrun_set", FW'(o_overrun), FW'(1));
        chk("ovr_frame_held", o_frame_out, frame_a);
        chk("ovr_busy", FW'(o_busy), FW'(1));
        idle(10);
        chk("ovr_single_result", FW'(o_rv_cnt - orv_before), FW'(1));
        chk("ovr_result_cycle", FW'(o_rv_cyc), FW'(ca + 2 + SO));
        chk("ovr_overrun_sticky", FW'(o_overrun), FW'(1));
        o_overrun_clr = 1'b1;
        idle(1);
        o_overrun_clr = 1'b0;
        chk("ovr_overrun_cleared", FW'(o_overrun), FW'(0));

        // 4: frame completes on the edge ending the result_valid cycle
        for (int i = 0; i < N; i++) send_o(W'(201 + i));
        d = cyc - 1;
        while (cyc < d + 7) idle(1);
        for (int i = 0; i < N; i++) frm[i] = W'(301 + i);
        frame_d = pack_frm();
        for (int i = 0; i < N - 1; i++) send_o(frm[i]);
        chk("rvcyc_result_valid", FW'(o_result_valid), FW'(1));
        chk("rvcyc_idle", FW'(o_busy), FW'(0));
        send_o(frm[N-1]);
        chk("rvcyc_load_busy", FW'(o_busy), FW'(1));
        chk("rvcyc_load_new_t", FW'(o_new_t), FW'(0));
        chk("rvcyc_load_frame", o_frame_out, frame_d);
        chk("rvcyc_no_overrun", FW'(o_overrun), FW'(0));
        idle(30);

        // 6: reset in RUN cycle 2 abandons the frame
        for (int i = 0; i < N; i++) frm[i] = W'(16'h0A00 + i);
        send_frame_m(0);
        idle(2);
        rv_before = rv_seen;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("reset_in_run");
        idle(2);
        rst_n = 1'b1;
        idle(10);
        chk("reset_no_result_valid", FW'(rv_seen - rv_before), FW'(0));
        chk_zero("after_reset");

        // wr_ptr restarted at 0: a fresh frame lands with sample 0 in t0
        for (int i = 0; i < N; i++) frm[i] = W'(i + 1);
        send_frame_m(0);
        idle(10);

        chk("pending_loads", FW'(load_q.size()), FW'(0));
        chk("pending_results", FW'(rv_q.size()), FW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
